// File: rtl/ysyx_22040386_wb_stage.sv
// rtl/ysyx_22040386_wb_stage.sv - write-back stage: selects the result, waits for load data, commits to the register file
module ysyx_22040386_wb_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic [XLEN-1:0]    in_result,
  input  logic [XLEN-1:0]    in_snpc,
  input  logic [XLEN-1:0]    in_pc_imm,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [2:0]         in_addr_lo,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_uns,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_rd_we,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_wen,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               commit_valid,
  output logic [XLEN-1:0]    commit_pc,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t               state, state_next;
  logic [XLEN-1:0]      pc_q, data_q;
  logic [RADDR_W-1:0]   rd_q;
  logic                 rd_we_q, uns_q;
  logic [2:0]           sel_q, off_q;
  logic [1:0]           size_q;

  logic                 xfer;
  logic [XLEN-1:0]      sel_val;
  logic [2:0]           off_eff;
  logic [XLEN-1:0]      shifted, mask, ld_val;
  logic                 sbit;

  assign in_ready = (state != WAIT_MEM);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    sel_val = in_result;
    case (in_sel)
      3'd1:    sel_val = in_snpc;
      3'd2:    sel_val = in_pc_imm;
      3'd3:    sel_val = in_imm;
      default: sel_val = in_result;
    endcase
  end

  // Offset is aligned down to the access size; a 32-bit datapath has no upper word.
  always_comb begin
    off_eff = off_q;
    if (XLEN == 32) off_eff[2] = 1'b0;
    case (size_q)
      2'd1:    off_eff[0] = 1'b0;
      2'd2:    off_eff[1:0] = 2'b00;
      default: if (size_q == 2'd3) off_eff = 3'b000;
    endcase
    shifted = mem_rdata >> {off_eff, 3'b000};
    case (size_q)
      2'd0:    begin mask = XLEN'(8'hFF);          sbit = shifted[7];  end
      2'd1:    begin mask = XLEN'(16'hFFFF);       sbit = shifted[15]; end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF);  sbit = shifted[31]; end
      default: begin mask = '1;                    sbit = shifted[31]; end
    endcase
    ld_val = (shifted & mask) | ((uns_q || !sbit) ? '0 : ~mask);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COMMIT: begin
        if (xfer) state_next = (in_sel == 3'd4) ? WAIT_MEM : COMMIT;
        else      state_next = IDLE;
      end
      WAIT_MEM: if (mem_rvalid) state_next = COMMIT;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      uns_q   <= 1'b0;
      sel_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      state <= state_next;
      if (xfer) begin
        pc_q    <= in_pc;
        data_q  <= sel_val;
        rd_q    <= in_rd;
        rd_we_q <= in_rd_we;
        uns_q   <= in_ld_uns;
        sel_q   <= in_sel;
        off_q   <= in_addr_lo;
        size_q  <= in_ld_size;
      end else if (state == WAIT_MEM && mem_rvalid && sel_q == 3'd4) begin
        data_q <= ld_val;
      end
    end
  end

  assign commit_valid = (state == COMMIT);
  assign commit_pc    = pc_q;
  assign rf_wen       = commit_valid && rd_we_q && (rd_q != '0);
  assign rf_waddr     = rd_q;
  assign rf_wdata     = data_q;
  assign fwd_valid    = rf_wen;
  assign fwd_rd       = rd_q;
  assign fwd_data     = data_q;

endmodule

// File: tb/tb_ysyx_22040386_wb_stage.sv
// tb/tb_ysyx_22040386_wb_stage.sv - directed self-checking bench for the write-back stage
module tb_ysyx_22040386_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [63:0] in_result, in_snpc, in_pc_imm, in_imm, in_pc;
  logic [2:0]  in_addr_lo;
  logic [1:0]  in_ld_size;
  logic        in_ld_uns;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_22040386_wb_stage #(.XLEN(64), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_result(in_result), .in_snpc(in_snpc), .in_pc_imm(in_pc_imm), .in_imm(in_imm),
    .in_pc(in_pc), .in_addr_lo(in_addr_lo), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [63:0] val, input logic [63:0] pc,
                       input logic [4:0] rd, input logic we);
    in_valid  = 1'b1;
    in_sel    = sel;
    in_result = (sel == 3'd0 || sel > 3'd4) ? val : 64'h0;
    in_snpc   = (sel == 3'd1) ? val : 64'h1111;
    in_pc_imm = (sel == 3'd2) ? val : 64'h2222;
    in_imm    = (sel == 3'd3) ? val : 64'h3333;
    in_pc     = pc;
    in_rd     = rd;
    in_rd_we  = we;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_result = '0; in_snpc = '0;
    in_pc_imm = '0; in_imm = '0; in_pc = '0; in_addr_lo = '0; in_ld_size = '0;
    in_ld_uns = 1'b0; in_rd = '0; in_rd_we = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    step(); step();
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_commit", 64'(commit_valid), 64'd0);
    chk("rst_fwd", 64'(fwd_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // pc_imm write-back
    drive(3'd2, 64'h8000_1000, 64'h100, 5'd5, 1'b1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("pcimm_commit", 64'(commit_valid), 64'd1);
    chk("pcimm_wen", 64'(rf_wen), 64'd1);
    chk("pcimm_waddr", 64'(rf_waddr), 64'd5);
    chk("pcimm_wdata", rf_wdata, 64'h8000_1000);
    chk("pcimm_pc", commit_pc, 64'h100);
    chk("pcimm_fwd", {fwd_data[58:0], fwd_rd}, {rf_wdata[58:0], 5'd5});
    chk("pcimm_fwdv", 64'(fwd_valid), 64'd1);
    step();
    chk("pcimm_idle", 64'(commit_valid), 64'd0);

    // signed byte load, offset 3, three wait cycles
    drive(3'd4, 64'h0, 64'h104, 5'd6, 1'b1);
    in_ld_size = 2'd0; in_ld_uns = 1'b0; in_addr_lo = 3'd3;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_wait_ready", 64'(in_ready), 64'd0);
      chk("lb_wait_commit", 64'(commit_valid), 64'd0);
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
    @(negedge clk);
    chk("lb_rv_nocommit", 64'(commit_valid), 64'd0);
    step(); mem_rvalid = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("lb_commit", 64'(commit_valid), 64'd1);
    chk("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_pc", commit_pc, 64'h104);
    chk("lb_wen", 64'(rf_wen), 64'd1);
    step();

    // unsigned half load, offset 6
    drive(3'd4, 64'h0, 64'h108, 5'd7, 1'b1);
    in_ld_size = 2'd1; in_ld_uns = 1'b1; in_addr_lo = 3'd6;
    step(); in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hBEEF_0000_0000_0000;
    step(); mem_rvalid = 1'b0;
    @(negedge clk);
    chk("lhu_wdata", rf_wdata, 64'h0000_0000_0000_BEEF);
    chk("lhu_waddr", 64'(rf_waddr), 64'd7);
    step();

    // signed word load, offset 5 aligns down to 4
    drive(3'd4, 64'h0, 64'h10C, 5'd8, 1'b1);
    in_ld_size = 2'd2; in_ld_uns = 1'b0; in_addr_lo = 3'd5;
    step(); in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h8765_4321_0000_0000;
    step(); mem_rvalid = 1'b0;
    @(negedge clk);
    chk("lw_wdata", rf_wdata, 64'hFFFF_FFFF_8765_4321);
    step();

    // rd = 0 commits without writing
    drive(3'd0, 64'h1234, 64'h110, 5'd0, 1'b1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("x0_commit", 64'(commit_valid), 64'd1);
    chk("x0_wen", 64'(rf_wen), 64'd0);
    chk("x0_fwd", 64'(fwd_valid), 64'd0);
    step();

    // reserved select falls back to result; rd_we=0 suppresses the write
    drive(3'd6, 64'hCAFE, 64'h114, 5'd9, 1'b0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("rsv_wdata", rf_wdata, 64'hCAFE);
    chk("rsv_wen", 64'(rf_wen), 64'd0);
    step();

    // three back-to-back non-loads
    drive(3'd0, 64'hA1, 64'h200, 5'd1, 1'b1);
    chk("b2b_ready0", 64'(in_ready), 64'd1);
    step();
    drive(3'd1, 64'hB2, 64'h204, 5'd2, 1'b1);
    @(negedge clk);
    chk("b2b_c0", {commit_pc[55:0], rf_wdata[7:0]}, {56'h200, 8'hA1});
    chk("b2b_v0", {62'd0, commit_valid, in_ready}, 64'd3);
    step();
    drive(3'd3, 64'hC3, 64'h208, 5'd3, 1'b1);
    @(negedge clk);
    chk("b2b_c1", {commit_pc[55:0], rf_wdata[7:0]}, {56'h204, 8'hB2});
    chk("b2b_v1", {62'd0, commit_valid, in_ready}, 64'd3);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c2", {commit_pc[55:0], rf_wdata[7:0]}, {56'h208, 8'hC3});
    chk("b2b_v2", {62'd0, commit_valid, in_ready}, 64'd3);
    chk("b2b_waddr2", 64'(rf_waddr), 64'd3);
    step();
    chk("b2b_idle", 64'(commit_valid), 64'd0);

    // reset while waiting on load data drops the load
    drive(3'd4, 64'h0, 64'h300, 5'd4, 1'b1);
    in_ld_size = 2'd3; in_ld_uns = 1'b0; in_addr_lo = 3'd0;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("rstw_wait", 64'(in_ready), 64'd0);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 64'(in_ready), 64'd1);
    chk("rstw_commit", 64'(commit_valid), 64'd0);
    step();
    @(negedge clk);
    chk("rstw_commit2", 64'(commit_valid), 64'd0);
    chk("rstw_wen", 64'(rf_wen), 64'd0);
    chk("rstw_pc", commit_pc, 64'h0);
    mem_rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040386_wb_stage.md
YSYX_22040386_WB_STAGE -- requirements
Module: ysyx_22040386_wb_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter RADDR_W, default 5, giving the register-file address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream (MEM stage) presents an instruction.
REQ-006 in_ready  output  1  the block can accept an instruction this cycle.
REQ-007 in_sel  input  3  write-back source: 0 result, 1 snpc, 2 pc_imm, 3 imm, 4 load data; 5-7 reserved.
REQ-008 in_result, in_snpc, in_pc_imm, in_imm, in_pc  input  XLEN each  candidate values and instruction PC.
REQ-009 in_addr_lo  input  3  low bits of the load address (byte offset).
REQ-010 in_ld_size  input  2  0 byte, 1 half, 2 word, 3 dword; in_ld_uns  input  1  zero-extend when 1.
REQ-011 in_rd  input  RADDR_W  destination register; in_rd_we  input  1  destination write enable.
REQ-012 mem_rvalid  input  1  load data valid; mem_rdata  input  XLEN  raw aligned memory doubleword/word.
REQ-013 rf_wen  output  1; rf_waddr  output  RADDR_W; rf_wdata  output  XLEN  register-file write port.
REQ-014 commit_valid  output  1; commit_pc  output  XLEN  retirement pulse and PC.
REQ-015 fwd_valid  output  1; fwd_rd  output  RADDR_W; fwd_data  output  XLEN  forwarding of the committing value.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_MEM and COMMIT.
REQ-017 in_ready SHALL be 1 in IDLE and COMMIT, 0 in WAIT_MEM; a transfer occurs when in_valid and in_ready are both 1.
REQ-018 On transfer, the block SHALL latch in_pc, in_rd, in_rd_we, in_sel, the load controls and the selected non-load value.
REQ-019 On transfer with in_sel=4, next state SHALL be WAIT_MEM; any other in_sel SHALL go to COMMIT; reserved in_sel values SHALL select in_result.
REQ-020 In WAIT_MEM, when mem_rvalid=1, the block SHALL latch the extracted load value and go to COMMIT; otherwise it SHALL stay, with no timeout.
REQ-021 Extraction: byte = rdata[8*off +: 8], half = rdata[8*off +: 16] (off bit0 ignored), word = rdata[8*off +: 32] (off bits1:0 ignored); sign- or zero-extend to XLEN per in_ld_uns.
REQ-022 For XLEN=32, off bit2 SHALL be ignored, and size 3 SHALL behave as word.
REQ-023 mem_rvalid SHALL be ignored in IDLE and COMMIT.
REQ-024 In COMMIT, commit_valid SHALL be 1 for exactly that cycle, and commit_pc SHALL equal the latched PC.
REQ-025 In COMMIT, rf_wen SHALL be 1 only if latched rd_we=1 and rd!=0; rf_waddr and rf_wdata SHALL carry the latched rd and data.
REQ-026 fwd_valid, fwd_rd and fwd_data SHALL equal rf_wen, rf_waddr and rf_wdata in the same cycle.
REQ-027 From COMMIT, a simultaneous transfer SHALL follow REQ-019; without one, next state SHALL be IDLE. Non-load throughput is one instruction per cycle.
REQ-028 Latency SHALL be: non-load transfer to commit 1 cycle; load transfer to commit 1 cycle after the mem_rvalid cycle.
REQ-029 Outside COMMIT, rf_wen, commit_valid and fwd_valid SHALL be 0.

Reset
REQ-030 With rst=1 at a clock edge, state SHALL become IDLE and all latched registers SHALL clear to 0, including mid-WAIT_MEM, where the pending load is dropped with no commit.
REQ-031 During and after reset, in_ready SHALL be 1, and rf_wen, commit_valid and fwd_valid SHALL be 0.
REQ-032 Reset SHALL take priority over a simultaneous transfer or mem_rvalid.

Verification
REQ-033 The bench SHALL cover: in_sel=2, in_pc_imm=0x80001000, rd=5, rd_we=1 -> next cycle rf_wen=1, waddr=5, wdata=0x80001000, commit_valid=1.
REQ-034 The bench SHALL cover: in_sel=4, size=0, uns=0, off=3, mem_rdata=0x00000000_80000000 after 3 wait cycles -> in_ready=0 while waiting, then wdata=0xFFFFFFFF_FFFFFF80.
REQ-035 The bench SHALL cover: in_sel=4, size=1, uns=1, off=6, mem_rdata=0xBEEF0000_00000000 -> wdata=0x00000000_0000BEEF.
REQ-036 The bench SHALL cover: rd=0, rd_we=1, in_sel=0 -> commit_valid=1, rf_wen=0, fwd_valid=0.
REQ-037 The bench SHALL cover: three back-to-back non-loads with in_valid held high -> three consecutive commit cycles in order, in_ready constant 1.
REQ-038 The bench SHALL cover: rst asserted in WAIT_MEM, followed by mem_rvalid=1 -> no commit, state IDLE, in_ready=1.
